// File: rtl/video_ram_arbiter.sv
// Video RAM arbiter: shares one single-port synchronous RAM between the
// hard real-time video fetcher (always wins, never stalls) and the CPU,
// which uses the free slots through a req/ack handshake.
module video_ram_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8,
  parameter int WAIT_LIMIT = 16,
  parameter int WAIT_W     = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_timeout,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT);
  localparam logic [WAIT_W-1:0] WAIT_PRE = WAIT_W'(WAIT_LIMIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  state_t            state;
  state_t            next_state;
  logic              cpu_grant;
  logic              access_we;
  logic [WAIT_W-1:0] wait_cnt;

  // The CPU only gets the port in IDLE when video is silent; the ack term
  // keeps a request that is released on the ack edge from being re-granted.
  always_comb begin
    cpu_grant = (state == IDLE) & cpu_req & ~vid_req & ~cpu_ack;
    ram_addr  = vid_req ? vid_addr : cpu_addr;
    ram_wdata = cpu_wdata;
    ram_we    = cpu_grant & cpu_we;
    vid_rdata = ram_rdata;
  end

  // CPU access state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: a granted access spends exactly one cycle in DATA.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cpu_grant) next_state = DATA;
      DATA:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered video valid, CPU ack and CPU read data capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vid_valid <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      access_we <= 1'b0;
    end else begin
      vid_valid <= vid_req;
      cpu_ack   <= (state == DATA);
      if (cpu_grant) begin
        access_we <= cpu_we;
      end
      if ((state == DATA) && !access_we) begin
        cpu_rdata <= ram_rdata;
      end
    end
  end

  // Starvation watch: count ungranted request cycles, latch a sticky timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt    <= '0;
      cpu_timeout <= 1'b0;
    end else if (!cpu_req || cpu_grant) begin
      wait_cnt <= '0;
    end else if ((state == IDLE) && !cpu_ack && (wait_cnt != WAIT_MAX)) begin
      wait_cnt <= wait_cnt + WAIT_ONE;
      if (wait_cnt == WAIT_PRE) begin
        cpu_timeout <= 1'b1;
      end
    end
  end

endmodule
